// File: rtl/cla_add_sched.sv
// cla_add_sched: two-requester round-robin scheduler sharing one 8-bit
// carry-lookahead adder for multi-byte add/subtract, one byte per cycle,
// LSB first, carry held in a register between bytes.
// Optional feature macro: CLA_SCHED_SUB_EN (subtract support; add-only when undefined).

// 8-bit carry-lookahead adder: every carry is a flat sum of products of
// generate/propagate terms rather than a ripple chain.
module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] p;
    logic [7:0] g;
    logic [8:0] c;
    logic       acc;
    logic       prod;

    // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (cin & p[0..i])
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        acc  = 1'b0;
        prod = 1'b0;
        c[0] = cin;
        for (int unsigned i = 0; i < 8; i++) begin
            acc = cin;
            for (int unsigned m = 0; m <= i; m++) begin
                acc = acc & p[m];
            end
            for (int unsigned j = 0; j <= i; j++) begin
                prod = g[j];
                for (int unsigned m = j + 1; m <= i; m++) begin
                    prod = prod & p[m];
                end
                acc = acc | prod;
            end
            c[i+1] = acc;
        end
        sum  = p ^ c[7:0];
        cout = c[8];
    end
endmodule

module cla_add_sched #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic                  req0_sub,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    input  logic                  req1_sub,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [8*NBYTES-1:0]   resp_sum,
    output logic                  resp_cout
);
    localparam int W = 8 * NBYTES;
    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic [2:0]     idx_q, idx_d;
    logic           id_q, id_d;
    logic           last_q, last_d;
    logic           cout_q, cout_d;

    logic           grant;
    logic           any_valid;
    logic           sub_sel;
    logic [7:0]     a_byte;
    logic [7:0]     b_byte;
    logic [7:0]     cla_sum;
    logic           cla_cout;

`ifndef CLA_SCHED_SUB_EN
    logic           unused_sub;
    assign unused_sub = req0_sub | req1_sub;
`endif

    cla_8bit u_cla (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // Round-robin grant, ready strobes and current operand byte selection
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = req1_valid;
        end
        req0_ready = (state_q == S_IDLE) && !rst && req0_valid && !grant;
        req1_ready = (state_q == S_IDLE) && !rst && req1_valid &&  grant;
`ifdef CLA_SCHED_SUB_EN
        sub_sel = grant ? req1_sub : req0_sub;
`else
        sub_sel = 1'b0;
`endif
        a_byte = '0;
        b_byte = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (idx_q == 3'(k)) begin
                a_byte = a_q[8*k +: 8];
                b_byte = b_q[8*k +: 8];
            end
        end
    end

    // Next-state logic: capture in IDLE, one byte per cycle in RUN, hold in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        id_d    = id_q;
        last_d  = last_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    a_d     = grant ? req1_a : req0_a;
                    b_d     = grant ? req1_b : req0_b;
                    if (sub_sel) begin
                        b_d = ~b_d;
                    end
                    carry_d = sub_sel;
                    idx_d   = '0;
                    id_d    = grant;
                    last_d  = grant;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int unsigned k = 0; k < NBYTES; k++) begin
                    if (idx_q == 3'(k)) begin
                        sum_d[8*k +: 8] = cla_sum;
                    end
                end
                carry_d = cla_cout;
                idx_d   = idx_q + 3'd1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = cla_cout;
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
        end
    end

    assign resp_valid = (state_q == S_DONE);
    assign resp_sum   = sum_q;
    assign resp_id    = id_q;
    assign resp_cout  = cout_q;
endmodule

// File: tb/tb_cla_add_sched.sv
// Bench for cla_add_sched (NBYTES=4): directed vectors, hold/backpressure,
// round-robin contention, reset abort and randomized ops against an
// arithmetic reference model.
module tb_cla_add_sched;
    localparam int NBYTES = 4;
    localparam int W = 8 * NBYTES;

    logic         clk;
    logic         rst;
    logic         req0_valid, req0_ready, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id, resp_cout;
    logic [W-1:0] resp_sum;

    int tests = 0;
    int fails = 0;

    cla_add_sched #(.NBYTES(NBYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: {cout, sum} of a + (sub ? ~b : b) + sub over W bits
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
        logic s;
`ifdef CLA_SCHED_SUB_EN
        s = sub;
`else
        s = 1'b0;
`endif
        return {1'b0, a} + {1'b0, (s ? ~b : b)} + (W+1)'(s);
    endfunction

    function automatic logic [W-1:0] rnd_word();
        return W'({$urandom, $urandom});
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        tests++; if (resp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b want 0", resp_valid);
        end
        tests++; if (resp_sum !== '0 || resp_cout !== 1'b0 || resp_id !== 1'b0) begin
            fails++; $display("FAIL reset_outputs: got sum=%h cout=%b id=%b want 0/0/0",
                              resp_sum, resp_cout, resp_id);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    // One operation from a single requester; hold>0 keeps resp_ready low that many
    // cycles in DONE while the other requester asserts valid.
    task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input int hold);
        logic [W:0] exp;
        int n;
        int lat;
        exp = model(a, b, sub);
        @(negedge clk);
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end
        #1;
        n = 0;
        while (!(id == 0 ? req0_ready : req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        tests++; if (n >= 20) begin
            fails++; $display("FAIL accept_timeout id=%0d: ready never rose", id);
        end
        @(posedge clk); #1;
        // scramble held data to prove it was captured on the accept edge
        if (id == 0) begin
            req0_valid = 1'b0; req0_a = rnd_word(); req0_b = rnd_word();
        end else begin
            req1_valid = 1'b0; req1_a = rnd_word(); req1_b = rnd_word();
        end
        // latency counted in cycles from the accept cycle
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(negedge clk); lat++;
        end
        tests++; if (lat !== NBYTES + 1) begin
            fails++; $display("FAIL latency id=%0d: got %0d want %0d", id, lat, NBYTES + 1);
        end
        tests++; if (resp_sum !== exp[W-1:0] || resp_cout !== exp[W] || resp_id !== 1'(id)) begin
            fails++; $display("FAIL result a=%h b=%h sub=%b: got sum=%h cout=%b id=%b want %h/%b/%0d",
                              a, b, sub, resp_sum, resp_cout, resp_id, exp[W-1:0], exp[W], id);
        end
        if (hold > 0) begin
            if (id == 0) begin
                req1_a = rnd_word(); req1_b = rnd_word(); req1_valid = 1'b1;
            end else begin
                req0_a = rnd_word(); req0_b = rnd_word(); req0_valid = 1'b1;
            end
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                tests++; if (resp_valid !== 1'b1 || resp_sum !== exp[W-1:0] ||
                             resp_cout !== exp[W] || resp_id !== 1'(id)) begin
                    fails++; $display("FAIL hold_stable cyc=%0d: got v=%b sum=%h cout=%b id=%b want 1/%h/%b/%0d",
                                      h, resp_valid, resp_sum, resp_cout, resp_id, exp[W-1:0], exp[W], id);
                end
                tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                    fails++; $display("FAIL hold_ready cyc=%0d: got %b%b want 00", h, req0_ready, req1_ready);
                end
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tests++; if (resp_valid !== 1'b0) begin
            fails++; $display("FAIL release_idle: got resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_directed();
        run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 3);
        run_op(1, 32'h0000_0000, 32'h0000_0000, 1'b1, 0);
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);
    endtask

    // Both requesters valid throughout: grants must alternate 0,1,0,1 after reset
    task automatic test_contention();
        logic [W:0] exp;
        int n;
        int got;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req0_a = rnd_word(); req0_b = rnd_word(); req0_sub = 1'($urandom_range(1));
        req1_a = rnd_word(); req1_b = rnd_word(); req1_sub = 1'($urandom_range(1));
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk); #1; n++;
            end
            got = req1_ready ? 1 : 0;
            tests++; if (n >= 20 || (req0_ready && req1_ready) || got != (t % 2)) begin
                fails++; $display("FAIL grant_order op=%0d: got ready=%b%b want id %0d",
                                  t, req1_ready, req0_ready, t % 2);
            end
            exp = got ? model(req1_a, req1_b, req1_sub) : model(req0_a, req0_b, req0_sub);
            @(posedge clk); #1;
            if (got == 1) begin
                req1_a = rnd_word(); req1_b = rnd_word(); req1_sub = 1'($urandom_range(1));
            end else begin
                req0_a = rnd_word(); req0_b = rnd_word(); req0_sub = 1'($urandom_range(1));
            end
            n = 0;
            while (!resp_valid && n < 40) begin
                @(negedge clk); n++;
            end
            tests++; if (resp_valid !== 1'b1 || resp_sum !== exp[W-1:0] ||
                         resp_cout !== exp[W] || resp_id !== 1'(t % 2)) begin
                fails++; $display("FAIL contention_result op=%0d: got v=%b sum=%h cout=%b id=%b want 1/%h/%b/%0d",
                                  t, resp_valid, resp_sum, resp_cout, resp_id, exp[W-1:0], exp[W], t % 2);
            end
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Reset during byte 2 aborts the op; no response, carry cleared for the next op
    task automatic test_reset_mid_run();
        int n;
        int seen;
        @(negedge clk);
        req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF; req0_sub = 1'b0; req0_valid = 1'b1;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        tests++; if (n >= 20) begin
            fails++; $display("FAIL abort_accept_timeout: ready never rose");
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        tests++; if (resp_valid !== 1'b0 || resp_sum !== '0 || resp_cout !== 1'b0 || resp_id !== 1'b0) begin
            fails++; $display("FAIL abort_state: got v=%b sum=%h cout=%b id=%b want 0/0/0/0",
                              resp_valid, resp_sum, resp_cout, resp_id);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        tests++; if (seen != 0) begin
            fails++; $display("FAIL abort_stale_resp: got %0d valid cycles want 0", seen);
        end
        run_op(0, 32'h0101_0101, 32'h0101_0101, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op(int'($urandom_range(1)), rnd_word(), rnd_word(),
                   1'($urandom_range(1)), int'($urandom_range(2)));
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_directed();
        test_contention();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
